present_round_ctrl: RTL and testbench
=====================================

// Module: present_round_ctrl
// PURPOSE
//  Sequencer for the iterative PRESENT block-cipher round datapath inside the present AXI4-Lite
//  peripheral. Accepts an encrypt/decrypt command from the register interface and steps the
//  external round datapath through load, NUM_ROUNDS rounds and the final key add. Holds the
//  result valid until the register interface accepts it. Keeps a completed-operation counter.
// PARAMETERS
//  NUM_ROUNDS  31                     number of round-datapath steps per operation
//  CNT_W       $clog2(NUM_ROUNDS+1)   width of the round index
//  OPCNT_W     16                     width of the completed-operation counter
// PORTS
//  ACLK          in   1        clock; all logic rising-edge
//  ARESETN       in   1        synchronous active-low reset
//  cmd_valid     in   1        command request from register interface
//  cmd_ready     out  1        command accepted when cmd_valid & cmd_ready
//  cmd_decrypt   in   1        0=encrypt, 1=decrypt; sampled on accept
//  abort         in   1        cancel current operation
//  dp_load       out  1        datapath: load plaintext/key registers
//  dp_round_en   out  1        datapath: perform one round this cycle
//  dp_round_idx  out  CNT_W    datapath: round counter to key schedule
//  dp_decrypt    out  1        datapath: inverse-round select (latched mode)
//  dp_final      out  1        datapath: final key add, capture result
//  out_valid     out  1        result register holds a valid block
//  out_ready     in   1        result consumed when out_valid & out_ready
//  busy          out  1        state != IDLE
//  op_count      out  OPCNT_W  number of completed (accepted-result) operations
//  irq           out  1        only when PRESENT_CTRL_IRQ_EN defined
//  irq_clr       in   1        only when PRESENT_CTRL_IRQ_EN defined
// BEHAVIOUR
//  - Reset (ARESETN=0 at a rising edge): state IDLE; all outputs 0 except cmd_ready=1;
//    op_count=0; dp_round_idx=0; latched mode=0. Reset mid-operation discards it, no out_valid.
//  - FSM, Moore outputs from registered state:
//    IDLE : cmd_ready=1. cmd_valid -> LOAD; latch cmd_decrypt.
//    LOAD : dp_load=1 for 1 cycle. round counter := 1 (enc) or NUM_ROUNDS (dec). -> RUN.
//    RUN  : dp_round_en=1, dp_round_idx=counter. enc: counter+1; dec: counter-1.
//           Exit to FINAL after the cycle with idx=NUM_ROUNDS (enc) or idx=1 (dec);
//           exactly NUM_ROUNDS RUN cycles.
//    FINAL: dp_final=1 for 1 cycle. -> HOLD.
//    HOLD : out_valid=1 until out_ready; on handshake op_count+1 (wraps 2^OPCNT_W-1 -> 0), -> IDLE.
//  - Latency: accept in cycle T; LOAD T+1; RUN T+2..T+1+NUM_ROUNDS; FINAL T+2+NUM_ROUNDS;
//    out_valid from T+3+NUM_ROUNDS (T+34 at default). Next accept earliest 1 cycle after HOLD exit.
//  - dp_round_idx is 0 outside RUN. dp_decrypt = latched mode, valid LOAD..FINAL, 0 in IDLE.
//  - cmd_ready=0 in all non-IDLE states; cmd_valid there is not accepted (no queueing).
//  - abort in LOAD/RUN/FINAL/HOLD -> IDLE next cycle; abort wins over out_ready in HOLD
//    (op_count unchanged). abort in IDLE ignored; abort & cmd_valid in IDLE: command accepted.
//  - Exactly one of dp_load/dp_round_en/dp_final high in any cycle, or none.
// CONFIGURATION
//  PRESENT_CTRL_IRQ_EN defined: irq/irq_clr ports exist; irq sets on FINAL->HOLD transition,
//    stays high until irq_clr=1 (clear wins if set and clear coincide? no: set wins), reset -> 0.
//  PRESENT_CTRL_IRQ_EN undefined: irq/irq_clr ports and their logic absent; completion
//    observable only via out_valid/busy. All other behaviour identical.
// TESTING
//  1 Reset then idle: ARESETN low 5 cycles -> cmd_ready=1, busy=0, out_valid=0, op_count=0.
//  2 Encrypt: cmd_valid=1,cmd_decrypt=0 at T -> dp_load@T+1; dp_round_idx 1..31 @T+2..T+32;
//    dp_final@T+33; out_valid@T+34; out_ready@T+36 -> IDLE@T+37, op_count=1.
//  3 Decrypt: cmd_decrypt=1 -> dp_decrypt=1, dp_round_idx 31 down to 1, same timing as 2.
//  4 Busy command + abort: cmd_valid during RUN idx=10 -> not accepted; abort@idx=12 ->
//    IDLE next cycle, out_valid never 1, op_count unchanged.
//  5 Wrap + backpressure: preload 65535 ops (force), hold out_ready=0 20 cycles -> out_valid
//    stays 1; then out_ready=1 -> op_count=0.
//  6 IRQ (macro on): op completes -> irq=1 from HOLD entry; irq_clr=1 1 cycle -> irq=0;
//    ARESETN low in RUN -> irq=0, state IDLE, no result.

Source files
------------

// File: rtl/present_round_ctrl.sv
// Round sequencer for the iterative PRESENT datapath: load, NUM_ROUNDS rounds, final key add, result hold.
// Optional completion interrupt (irq/irq_clr) built when PRESENT_CTRL_IRQ_EN is defined.
module present_round_ctrl #(
   parameter int unsigned NUM_ROUNDS = 31,
   parameter int unsigned CNT_W      = $clog2(NUM_ROUNDS + 1),
   parameter int unsigned OPCNT_W    = 16
) (
   input  logic               ACLK,
   input  logic               ARESETN,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_decrypt,
   input  logic               abort,
   output logic               dp_load,
   output logic               dp_round_en,
   output logic [CNT_W-1:0]   dp_round_idx,
   output logic               dp_decrypt,
   output logic               dp_final,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic [OPCNT_W-1:0] op_count
`ifdef PRESENT_CTRL_IRQ_EN
   ,
   output logic               irq,
   input  logic               irq_clr
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_FINAL = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] IDX_FIRST = CNT_W'(1);
   localparam logic [CNT_W-1:0] IDX_LAST  = CNT_W'(NUM_ROUNDS);

   state_t               r_state;
   logic                 r_mode;
   logic                 r_cmd_ready;
   logic                 r_dp_load;
   logic                 r_dp_round_en;
   logic [CNT_W-1:0]     r_dp_round_idx;
   logic                 r_dp_decrypt;
   logic                 r_dp_final;
   logic                 r_out_valid;
   logic                 r_busy;
   logic [OPCNT_W-1:0]   r_op_count;

   logic                 w_illegal;
   logic                 w_done;
   logic                 w_to_idle;
   logic [CNT_W-1:0]     w_idx_end;

   // Abort, result handshake and stray encodings all funnel into the same return-to-idle path.
   assign w_illegal = (r_state != S_IDLE) && (r_state != S_LOAD) && (r_state != S_RUN) &&
                      (r_state != S_FINAL) && (r_state != S_HOLD);
   assign w_done    = (r_state == S_HOLD) && out_ready && !abort;
   assign w_to_idle = ((r_state != S_IDLE) && abort) || w_done || w_illegal;
   assign w_idx_end = r_mode ? IDX_FIRST : IDX_LAST;

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         r_state        <= S_IDLE;
         r_mode         <= 1'b0;
         r_cmd_ready    <= 1'b1;
         r_dp_load      <= 1'b0;
         r_dp_round_en  <= 1'b0;
         r_dp_round_idx <= '0;
         r_dp_decrypt   <= 1'b0;
         r_dp_final     <= 1'b0;
         r_out_valid    <= 1'b0;
         r_busy         <= 1'b0;
         r_op_count     <= '0;
      end else begin
         r_dp_load  <= 1'b0;
         r_dp_final <= 1'b0;
         if (w_to_idle) begin
            r_state        <= S_IDLE;
            r_cmd_ready    <= 1'b1;
            r_dp_round_en  <= 1'b0;
            r_dp_round_idx <= '0;
            r_dp_decrypt   <= 1'b0;
            r_out_valid    <= 1'b0;
            r_busy         <= 1'b0;
            if (w_done) r_op_count <= r_op_count + OPCNT_W'(1);
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (cmd_valid) begin
                     r_state      <= S_LOAD;
                     r_mode       <= cmd_decrypt;
                     r_cmd_ready  <= 1'b0;
                     r_dp_load    <= 1'b1;
                     r_dp_decrypt <= cmd_decrypt;
                     r_busy       <= 1'b1;
                  end
               end
               S_LOAD: begin
                  r_state        <= S_RUN;
                  r_dp_round_en  <= 1'b1;
                  r_dp_round_idx <= r_mode ? IDX_LAST : IDX_FIRST;
               end
               S_RUN: begin
                  if (r_dp_round_idx == w_idx_end) begin
                     r_state        <= S_FINAL;
                     r_dp_round_en  <= 1'b0;
                     r_dp_round_idx <= '0;
                     r_dp_final     <= 1'b1;
                  end else if (r_mode) begin
                     r_dp_round_idx <= r_dp_round_idx - CNT_W'(1);
                  end else begin
                     r_dp_round_idx <= r_dp_round_idx + CNT_W'(1);
                  end
               end
               S_FINAL: begin
                  r_state     <= S_HOLD;
                  r_out_valid <= 1'b1;
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign cmd_ready    = r_cmd_ready;
   assign dp_load      = r_dp_load;
   assign dp_round_en  = r_dp_round_en;
   assign dp_round_idx = r_dp_round_idx;
   assign dp_decrypt   = r_dp_decrypt;
   assign dp_final     = r_dp_final;
   assign out_valid    = r_out_valid;
   assign busy         = r_busy;
   assign op_count     = r_op_count;

`ifdef PRESENT_CTRL_IRQ_EN
   logic r_irq;
   logic w_irq_set;

   // Set on entry to HOLD; a coincident clear loses.
   assign w_irq_set = (r_state == S_FINAL) && !abort;

   always_ff @(posedge ACLK) begin
      if (!ARESETN)       r_irq <= 1'b0;
      else if (w_irq_set) r_irq <= 1'b1;
      else if (irq_clr)   r_irq <= 1'b0;
   end

   assign irq = r_irq;
`endif

endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl: per-cycle datapath trace scoreboard plus abort/reset/wrap scenarios.
module tb_present_round_ctrl;

   localparam int unsigned NR      = 31;
   localparam int unsigned CW      = 5;
   localparam int unsigned OW      = 16;
   localparam int          K_HOLD  = NR + 3;

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic          cmd_valid, cmd_ready, cmd_decrypt, abort;
   logic          dp_load, dp_round_en, dp_decrypt, dp_final;
   logic [CW-1:0] dp_round_idx;
   logic          out_valid, out_ready, busy;
   logic [OW-1:0] op_count;
`ifdef PRESENT_CTRL_IRQ_EN
   logic          irq, irq_clr;
`endif

   int errors = 0;
   int checks = 0;
   logic [OW-1:0] m_op_count;

   typedef struct packed {
      logic          ld;
      logic          re;
      logic [CW-1:0] idx;
      logic          fin;
      logic          dec;
      logic          ov;
      logic          bsy;
      logic          rdy;
   } trace_t;

   trace_t sb_q[$];

   present_round_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW), .OPCNT_W(OW)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_decrypt(cmd_decrypt), .abort(abort),
      .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx),
      .dp_decrypt(dp_decrypt), .dp_final(dp_final),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .op_count(op_count)
`ifdef PRESENT_CTRL_IRQ_EN
      , .irq(irq), .irq_clr(irq_clr)
`endif
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected outputs k cycles after the accept edge (k=1 is LOAD); dec is not checked in HOLD.
   function automatic trace_t exp_at(input int k, input logic dec);
      trace_t t;
      t     = '0;
      t.bsy = 1'b1;
      if (k == 1) t.ld = 1'b1;
      else if (k <= NR + 1) begin
         t.re  = 1'b1;
         t.idx = dec ? CW'(NR + 2 - k) : CW'(k - 1);
      end else if (k == NR + 2) t.fin = 1'b1;
      else t.ov = 1'b1;
      t.dec = (k < K_HOLD) ? dec : 1'b0;
      return t;
   endfunction

   function automatic trace_t obs(input int k);
      trace_t t;
      t.ld  = dp_load;
      t.re  = dp_round_en;
      t.idx = dp_round_idx;
      t.fin = dp_final;
      t.dec = (k < K_HOLD) ? dp_decrypt : 1'b0;
      t.ov  = out_valid;
      t.bsy = busy;
      t.rdy = cmd_ready;
      return t;
   endfunction

   task automatic check_idle(input string name);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || dp_load !== 1'b0 ||
          dp_round_en !== 1'b0 || dp_final !== 1'b0 || dp_round_idx !== '0 || dp_decrypt !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: rdy=%b busy=%b ov=%b ld=%b re=%b idx=%0d fin=%b dec=%b required rdy=1 others 0",
                  name, cmd_ready, busy, out_valid, dp_load, dp_round_en, dp_round_idx, dp_final, dp_decrypt);
      end
      checks++;
      if (op_count !== m_op_count) begin
         errors++;
         $display("FAIL %s op_count: got %0d required %0d", name, op_count, m_op_count);
      end
   endtask

   // Accept a command, check the scoreboarded trace, then release the result at cycle ready_k.
   task automatic run_op(input string name, input logic dec, input int ready_k);
      trace_t e, o;
      @(negedge ACLK);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s accept: cmd_ready=%b required 1", name, cmd_ready);
      end
      cmd_valid   = 1'b1;
      cmd_decrypt = dec;
      for (int k = 1; k <= K_HOLD; k++) sb_q.push_back(exp_at(k, dec));
      for (int k = 1; k <= K_HOLD; k++) begin
         @(negedge ACLK);
         if (k == 1) cmd_valid = 1'b0;
         e = sb_q.pop_front();
         o = obs(k);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s trace k=%0d: got %h required %h", name, k, o, e);
         end
      end
      for (int k = K_HOLD + 1; k <= ready_k; k++) begin
         @(negedge ACLK);
         checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s hold k=%0d: ov=%b busy=%b required 1 1", name, k, out_valid, busy);
         end
      end
      out_ready = 1'b1;
      @(negedge ACLK);
      out_ready  = 1'b0;
      m_op_count = m_op_count + OW'(1);
      check_idle(name);
   endtask

   task automatic start_and_step(input logic dec, input int n);
      @(negedge ACLK);
      cmd_valid   = 1'b1;
      cmd_decrypt = dec;
      @(negedge ACLK);
      cmd_valid = 1'b0;
      for (int k = 2; k <= n; k++) @(negedge ACLK);
   endtask

   task automatic test_reset;
      ARESETN = 1'b0; cmd_valid = 1'b0; cmd_decrypt = 1'b0; abort = 1'b0; out_ready = 1'b0;
`ifdef PRESENT_CTRL_IRQ_EN
      irq_clr = 1'b0;
`endif
      m_op_count = '0;
      repeat (5) @(posedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      check_idle("reset");
`ifdef PRESENT_CTRL_IRQ_EN
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset irq: got %b required 0", irq); end
`endif
   endtask

   task automatic test_encrypt;  run_op("encrypt", 1'b0, K_HOLD + 2); endtask
   task automatic test_decrypt;  run_op("decrypt", 1'b1, K_HOLD + 2); endtask

   task automatic test_busy_abort;
      trace_t e, o;
      int bad = 0;
      @(negedge ACLK);
      cmd_valid = 1'b1; cmd_decrypt = 1'b0;
      for (int k = 1; k <= 14; k++) sb_q.push_back(exp_at(k, 1'b0));
      for (int k = 1; k <= 13; k++) begin
         @(negedge ACLK);
         cmd_valid = (k == 11);
         e = sb_q.pop_front();
         o = obs(k);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL busy_abort trace k=%0d: got %h required %h", k, o, e);
         end
         if (k == 13) abort = 1'b1;
      end
      sb_q.delete();
      @(negedge ACLK);
      abort = 1'b0;
      check_idle("busy_abort");
      for (int k = 0; k < 40; k++) begin
         @(negedge ACLK);
         if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL busy_abort quiet: %0d bad cycles required 0", bad); end
   endtask

   task automatic test_abort_idle_cmd;
      @(negedge ACLK);
      abort = 1'b1; cmd_valid = 1'b1; cmd_decrypt = 1'b1;
      @(negedge ACLK);
      cmd_valid = 1'b0;
      checks++;
      if (dp_load !== 1'b1 || busy !== 1'b1 || dp_decrypt !== 1'b1) begin
         errors++;
         $display("FAIL abort_idle_cmd load: ld=%b busy=%b dec=%b required 1 1 1", dp_load, busy, dp_decrypt);
      end
      @(negedge ACLK);
      abort = 1'b0;
      check_idle("abort_load");
   endtask

   task automatic test_abort_hold;
      start_and_step(1'b0, K_HOLD);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_hold ov: got %b required 1", out_valid); end
      abort = 1'b1; out_ready = 1'b1;
      @(negedge ACLK);
      abort = 1'b0; out_ready = 1'b0;
      check_idle("abort_hold");
   endtask

   task automatic test_back_to_back;
      run_op("b2b_a", 1'b0, K_HOLD);
      run_op("b2b_b", 1'b1, K_HOLD);
   endtask

   task automatic test_wrap;
      @(negedge ACLK);
      force dut.r_op_count = 16'hFFFF;
      @(negedge ACLK);
      release dut.r_op_count;
      m_op_count = 16'hFFFF;
      @(negedge ACLK);
      checks++;
      if (op_count !== m_op_count) begin errors++; $display("FAIL wrap preload: got %0d required %0d", op_count, m_op_count); end
      run_op("wrap", 1'b0, K_HOLD + 20);
   endtask

   task automatic do_reset_mid(input string name);
      int bad = 0;
      start_and_step(1'b0, 10);
      ARESETN = 1'b0;
      repeat (2) @(negedge ACLK);
      ARESETN    = 1'b1;
      m_op_count = '0;
      check_idle(name);
`ifdef PRESENT_CTRL_IRQ_EN
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL %s irq: got %b required 0", name, irq); end
`endif
      for (int k = 0; k < 40; k++) begin
         @(negedge ACLK);
         if (out_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL %s no result: %0d bad cycles required 0", name, bad); end
   endtask

   task automatic test_reset_mid; do_reset_mid("reset_mid"); endtask

`ifdef PRESENT_CTRL_IRQ_EN
   task automatic test_irq;
      run_op("irq_op1", 1'b0, K_HOLD + 1);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq set: got %b required 1", irq); end
      irq_clr = 1'b1;
      @(negedge ACLK);
      irq_clr = 1'b0;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq clear: got %b required 0", irq); end
      run_op("irq_op2", 1'b1, K_HOLD);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq reset: got %b required 1", irq); end
      do_reset_mid("irq_reset");
   endtask
`endif

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_busy_abort();
      test_abort_idle_cmd();
      test_abort_hold();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
`ifdef PRESENT_CTRL_IRQ_EN
      test_irq();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
